// File: rtl/pong_state_writer.sv
// Pong game-state engine: paddle/ball step per frame tick, then the object block is written to the shared object RAM, one byte per cycle.
// Latency: tick sampled at edge k, RAM writes on edges k+3..k+10 (k+3..k+12 with scores), idle again at k+11 (k+13).
// Backpressure: none; a tick seen while busy is dropped and reported by a one-cycle o_tick_miss pulse.
// Optional feature: define PONG_SCORE_EN to add two wrapping score counters written at RAM addresses 8 and 9.
module pong_state_writer #(
  parameter int FIELD_W  = 120,
  parameter int FIELD_H  = 68,
  parameter int PADDLE_H = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_tick,
  input  logic       i_p1_up,
  input  logic       i_p1_down,
  input  logic       i_p2_up,
  input  logic       i_p2_down,
  output logic       o_ram_we,
  output logic [5:0] o_ram_address,
  output logic [7:0] o_ram_data,
  output logic       o_busy,
  output logic       o_tick_miss
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MOVE  = 2'd1;
  localparam logic [1:0] S_BALL  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  // Paddle columns never move; they are written from constants.
  localparam logic [7:0] P1_X    = 8'd1;
  localparam logic [7:0] P2_X    = 8'(FIELD_W - 2);
  localparam logic [7:0] PAD_H   = 8'(PADDLE_H);
  localparam logic [7:0] PAD_HM1 = 8'(PADDLE_H - 1);
  localparam logic [7:0] Y_MAX   = 8'(FIELD_H - PADDLE_H);
  localparam logic [7:0] Y_START = 8'((FIELD_H - PADDLE_H) / 2);
  localparam logic [7:0] X_MID   = 8'(FIELD_W / 2);
  localparam logic [7:0] Y_MID   = 8'(FIELD_H / 2);
  localparam logic [7:0] X_LAST  = 8'(FIELD_W - 1);
  localparam logic [7:0] Y_LAST  = 8'(FIELD_H - 1);

`ifdef PONG_SCORE_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  logic [1:0] state;
  logic [3:0] wr_idx;
  logic [7:0] p1_y, p2_y;
  logic [7:0] ball_x, ball_y;
  logic       dx_neg, dy_neg;   // 1 means the ball moves by -1 on that axis

  logic [7:0] bx_n, by_n;
  logic       dx_n, dy_n;
  logic       miss_p1, miss_p2;
  logic       p1_hit, p2_hit;
  logic [7:0] wr_byte;

`ifdef PONG_SCORE_EN
  logic [7:0] score1, score2;
`endif

  // One-cell paddle move with saturation at both ends; both buttons cancel.
  function automatic logic [7:0] paddle_next(input logic [7:0] y, input logic up, input logic down);
    paddle_next = y;
    if (up && !down && (y != 8'd0))
      paddle_next = y - 8'd1;
    else if (down && !up && (y < Y_MAX))
      paddle_next = y + 8'd1;
  endfunction

  // Next ball position/direction from walls, paddles (already moved this frame) and misses.
  always_comb begin
    dy_n    = dy_neg;
    dx_n    = dx_neg;
    bx_n    = ball_x;
    by_n    = ball_y;
    p1_hit  = dx_neg && (ball_x == P1_X + 8'd1) &&
              (ball_y >= p1_y) && (ball_y <= p1_y + PAD_HM1);
    p2_hit  = !dx_neg && (ball_x == P2_X - 8'd1) &&
              (ball_y >= p2_y) && (ball_y <= p2_y + PAD_HM1);
    miss_p1 = dx_neg && (ball_x == 8'd0);
    miss_p2 = !dx_neg && (ball_x == X_LAST);
    if ((dy_neg && (ball_y == 8'd0)) || (!dy_neg && (ball_y == Y_LAST)))
      dy_n = !dy_neg;
    if (p1_hit)
      dx_n = 1'b0;
    if (p2_hit)
      dx_n = 1'b1;
    if (miss_p1 || miss_p2) begin
      // Re-serve from the centre toward whoever conceded; vertical direction is kept.
      bx_n = X_MID;
      by_n = Y_MID;
      dx_n = miss_p1;
      dy_n = dy_neg;
    end else begin
      bx_n = dx_n ? (ball_x - 8'd1) : (ball_x + 8'd1);
      by_n = dy_n ? (ball_y - 8'd1) : (ball_y + 8'd1);
    end
  end

  // Byte presented for the current write slot of the object block.
  always_comb begin
    wr_byte = 8'd0;
    case (wr_idx)
      4'd0: wr_byte = P1_X;
      4'd1: wr_byte = p1_y;
      4'd2: wr_byte = PAD_H;
      4'd3: wr_byte = P2_X;
      4'd4: wr_byte = p2_y;
      4'd5: wr_byte = PAD_H;
      4'd6: wr_byte = ball_x;
      4'd7: wr_byte = ball_y;
`ifdef PONG_SCORE_EN
      4'd8: wr_byte = score1;
      4'd9: wr_byte = score2;
`endif
      default: wr_byte = 8'd0;
    endcase
  end

  // Frame sequencer: accept tick, step paddles, step ball, stream the block; flag ticks that arrive while busy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      wr_idx        <= 4'd0;
      o_ram_we      <= 1'b0;
      o_ram_address <= 6'd0;
      o_ram_data    <= 8'd0;
      o_busy        <= 1'b0;
      o_tick_miss   <= 1'b0;
    end else begin
      o_tick_miss <= i_frame_tick && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (i_frame_tick) begin
            state  <= S_MOVE;
            o_busy <= 1'b1;
          end
        end
        S_MOVE: state <= S_BALL;
        S_BALL: begin
          wr_idx <= 4'd0;
          state  <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_idx <= LAST_IDX) begin
            o_ram_we      <= 1'b1;
            o_ram_address <= {2'b00, wr_idx};
            o_ram_data    <= wr_byte;
            wr_idx        <= wr_idx + 4'd1;
          end else begin
            o_ram_we      <= 1'b0;
            o_ram_address <= 6'd0;
            o_ram_data    <= 8'd0;
            o_busy        <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Paddle positions update once per frame in the MOVE step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p1_y <= Y_START;
      p2_y <= Y_START;
    end else if (state == S_MOVE) begin
      p1_y <= paddle_next(p1_y, i_p1_up, i_p1_down);
      p2_y <= paddle_next(p2_y, i_p2_up, i_p2_down);
    end
  end

  // Ball position and direction update once per frame in the BALL step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ball_x <= X_MID;
      ball_y <= Y_MID;
      dx_neg <= 1'b0;
      dy_neg <= 1'b0;
    end else if (state == S_BALL) begin
      ball_x <= bx_n;
      ball_y <= by_n;
      dx_neg <= dx_n;
      dy_neg <= dy_n;
    end
  end

`ifdef PONG_SCORE_EN
  // A miss credits the opposite player; counters wrap naturally at 8 bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      score1 <= 8'd0;
      score2 <= 8'd0;
    end else if (state == S_BALL) begin
      if (miss_p1)
        score2 <= score2 + 8'd1;
      if (miss_p2)
        score1 <= score1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pong_state_writer.sv
// Directed plus tracking-random frames for pong_state_writer, checked against a behavioural game model.
// Every RAM write, busy and tick-miss cycle of each frame is compared; misses resynchronise via reset.
module tb_pong_state_writer;

`ifdef PONG_SCORE_EN
  localparam int NW = 10;
`else
  localparam int NW = 8;
`endif
  localparam int YMAX = 58;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_frame_tick = 1'b0;
  logic       i_p1_up = 1'b0, i_p1_down = 1'b0, i_p2_up = 1'b0, i_p2_down = 1'b0;
  logic       o_ram_we;
  logic [5:0] o_ram_address;
  logic [7:0] o_ram_data;
  logic       o_busy;
  logic       o_tick_miss;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural game state
  int m_p1y, m_p2y, m_bx, m_by, m_dx, m_dy, m_s1, m_s2;
  bit m_missed;
  logic [7:0] last_wr [10];

  pong_state_writer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_tick(i_frame_tick),
    .i_p1_up(i_p1_up), .i_p1_down(i_p1_down), .i_p2_up(i_p2_up), .i_p2_down(i_p2_down),
    .o_ram_we(o_ram_we), .o_ram_address(o_ram_address), .o_ram_data(o_ram_data),
    .o_busy(o_busy), .o_tick_miss(o_tick_miss)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p1y = 29; m_p2y = 29; m_bx = 60; m_by = 34;
    m_dx = 1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_missed = 0;
  endtask

  function automatic int move_paddle(input int y, input logic up, input logic down);
    int r;
    r = y;
    if (up && !down) r = y - 1;
    if (down && !up) r = y + 1;
    if (r < 0) r = 0;
    if (r > YMAX) r = YMAX;
    return r;
  endfunction

  // btn = {p1_up, p1_down, p2_up, p2_down}
  task automatic model_step(input logic [3:0] btn);
    m_p1y = move_paddle(m_p1y, btn[3], btn[2]);
    m_p2y = move_paddle(m_p2y, btn[1], btn[0]);
    m_missed = 0;
    if ((m_by == 0 && m_dy < 0) || (m_by == 67 && m_dy > 0)) m_dy = -m_dy;
    if (m_dx < 0 && m_bx == 2 && m_by >= m_p1y && m_by <= m_p1y + 9) m_dx = 1;
    else if (m_dx > 0 && m_bx == 117 && m_by >= m_p2y && m_by <= m_p2y + 9) m_dx = -1;
    if (m_dx < 0 && m_bx == 0) begin
      m_bx = 60; m_by = 34; m_s2 = (m_s2 + 1) % 256; m_missed = 1;
    end else if (m_dx > 0 && m_bx == 119) begin
      m_bx = 60; m_by = 34; m_s1 = (m_s1 + 1) % 256; m_missed = 1;
    end else begin
      m_bx = m_bx + m_dx;
      m_by = m_by + m_dy;
    end
  endtask

  function automatic logic [7:0] exp_byte(input int a);
    case (a)
      0: return 8'd1;
      1: return 8'(m_p1y);
      2: return 8'd10;
      3: return 8'd118;
      4: return 8'(m_p2y);
      5: return 8'd10;
      6: return 8'(m_bx);
      7: return 8'(m_by);
      8: return 8'(m_s1);
      default: return 8'(m_s2);
    endcase
  endfunction

  task automatic apply_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_frame_tick = 1'b0;
    {i_p1_up, i_p1_down, i_p2_up, i_p2_down} = 4'b0000;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
  endtask

  // One frame; extra_j > 1 raises a second tick sampled at edge k+extra_j.
  task automatic do_frame(input logic [3:0] btn, input int extra_j);
    @(negedge i_clk);
    {i_p1_up, i_p1_down, i_p2_up, i_p2_down} = btn;
    i_frame_tick = 1'b1;
    @(negedge i_clk);
    i_frame_tick = 1'b0;
    check("busy_at_k", o_busy, 1);
    check("we_at_k", o_ram_we, 0);
    model_step(btn);
    for (int j = 1; j <= NW + 4; j++) begin
      @(negedge i_clk);
      i_frame_tick = (j + 1 == extra_j);
      check("tick_miss", o_tick_miss, (j == extra_j));
      check("busy", o_busy, (j <= NW + 2));
      if (j >= 3 && j <= NW + 2) begin
        check("we", o_ram_we, 1);
        check("addr", o_ram_address, j - 3);
        check("data", o_ram_data, exp_byte(j - 3));
        last_wr[j-3] = o_ram_data;
      end else begin
        check("we_idle", o_ram_we, 0);
        if (j > NW + 2) check("addr_idle", o_ram_address, 0);
      end
    end
  endtask

  initial begin
    logic [3:0] btn;
    int extra;
    model_reset();

    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst_we", o_ram_we, 0);
    check("rst_addr", o_ram_address, 0);
    check("rst_data", o_ram_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_miss", o_tick_miss, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // First frame from reset, no buttons
    do_frame(4'b0000, 0);
    check("first_p1y", last_wr[1], 29);
    check("first_bx", last_wr[6], 61);
    check("first_by", last_wr[7], 35);

    // Hold p1 up: saturates at 0
    for (int i = 0; i < 35; i++) do_frame(4'b1000, 0);
    check("p1y_sat0", last_wr[1], 0);
    do_frame(4'b1100, 0);
    check("p1y_both", last_wr[1], 0);

    // Second tick 4 cycles after the first, then one on the returning edge
    do_frame(4'b0000, 4);
    do_frame(4'b0000, NW + 3);

    // Reset during the write of address 4
    @(negedge i_clk);
    i_frame_tick = 1'b1;
    @(negedge i_clk);
    i_frame_tick = 1'b0;
    repeat (7) @(negedge i_clk);
    check("mid_we", o_ram_we, 1);
    check("mid_addr", o_ram_address, 4);
    i_rst_n = 1'b0;
    #1;
    check("async_we", o_ram_we, 0);
    check("async_busy", o_busy, 0);
    check("async_addr", o_ram_address, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    do_frame(4'b0000, 0);
    check("post_rst_p1y", last_wr[1], 29);
    check("post_rst_bx", last_wr[6], 61);
    check("post_rst_by", last_wr[7], 35);

    // Random play: paddles mostly track the ball so hits and misses both occur
    for (int f = 0; f < 300; f++) begin
      btn = 4'b0000;
      if (m_by < m_p1y + 4) btn[3] = 1'b1; else if (m_by > m_p1y + 5) btn[2] = 1'b1;
      if (m_by < m_p2y + 4) btn[1] = 1'b1; else if (m_by > m_p2y + 5) btn[0] = 1'b1;
      if ($urandom_range(0, 3) == 0) btn[3:2] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) btn[1:0] = 2'($urandom_range(0, 3));
      extra = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, NW + 3)) : 0;
      do_frame(btn, extra);
      if (m_missed) begin
        check("miss_bx", last_wr[6], 60);
        check("miss_by", last_wr[7], 34);
        apply_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
